// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered kc, odd-parity frame check, timeout recovery,
// receive FIFO and a small four-register slave interface with a level interrupt.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_cs_n,
  input  logic [1:0] s_address,
  input  logic       s_read,
  output logic [7:0] s_readdata,
  input  logic       s_write,
  input  logic [7:0] s_writedata,
  output logic       irq,
  input  logic       kc,
  input  logic       kd
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            kc_s1, kc_s2, kd_s1, kd_s2;
  logic            kc_filt;
  logic [FW-1:0]   filt_cnt;
  logic            fall_now;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TW-1:0]   to_cnt;
  logic            timeout_hit;
  logic            to_err;
  logic            frame_done, frame_ok;
  logic [7:0]      rx_byte;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     level;
  logic            empty, full, push, pop, do_push;

  logic            overrun, frame_err, irq_en, rx_en;
  logic            rd, wr, clr;
  logic [7:0]      status;
  logic            unused_wdata;

  assign unused_wdata = ^s_writedata[7:4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc_s1 <= 1'b1;
      kc_s2 <= 1'b1;
      kd_s1 <= 1'b1;
      kd_s2 <= 1'b1;
    end else begin
      kc_s1 <= kc;
      kc_s2 <= kc_s1;
      kd_s1 <= kd;
      kd_s2 <= kd_s1;
    end
  end

  // filt_cnt counts consecutive synchronised samples that disagree with the filtered level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kc_filt  <= 1'b1;
      filt_cnt <= '0;
    end else if (kc_s2 == kc_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      kc_filt  <= kc_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  assign fall_now    = kc_filt & ~kc_s2 & (filt_cnt == FW'(FILTER_LEN - 1));
  assign timeout_hit = rx_en & (state != IDLE) & ~fall_now & (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!rx_en) begin
      state_nxt = IDLE;
    end else if (fall_now) begin
      case (state)
        IDLE:    if (!kd_s2) state_nxt = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = IDLE;
    end
  end

  // Frame datapath; the completed byte is handed to the FIFO one cycle after the stop sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      to_err     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      rx_byte    <= '0;
    end else begin
      frame_done <= 1'b0;
      to_err     <= timeout_hit;
      if (state == IDLE || fall_now || !rx_en) to_cnt <= '0;
      else                                     to_cnt <= to_cnt + TW'(1);
      if (rx_en && fall_now) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift   <= {kd_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= kd_s2;
          STOP: begin
            frame_done <= 1'b1;
            frame_ok   <= (^{shift, par_bit}) & kd_s2;
            rx_byte    <= shift;
          end
          default: ;
        endcase
      end
    end
  end

  assign rd      = ~s_cs_n & s_read;
  assign wr      = ~s_cs_n & s_write;
  assign clr     = wr & (s_address == 2'd3);
  assign empty   = (level == '0);
  assign full    = (level == (AW + 1)'(FIFO_DEPTH));
  assign push    = frame_done & frame_ok;
  assign pop     = rd & (s_address == 2'd0) & ~empty;
  assign do_push = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !pop)      level <= level + (AW + 1)'(1);
      else if (pop && !do_push) level <= level - (AW + 1)'(1);
    end
  end

  // A set request in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      irq_en    <= 1'b0;
      rx_en     <= 1'b1;
      irq       <= 1'b0;
    end else begin
      overrun   <= (push & full & ~pop) | (overrun & ~(clr & s_writedata[2]));
      frame_err <= (frame_done & ~frame_ok) | to_err | (frame_err & ~(clr & s_writedata[3]));
      if (wr && s_address == 2'd2) begin
        irq_en <= s_writedata[0];
        rx_en  <= s_writedata[1];
      end
      irq <= irq_en & (~empty | overrun | frame_err);
    end
  end

  assign status = {3'b000, (state != IDLE), frame_err, overrun, full, ~empty};

  always_comb begin
    s_readdata = 8'h00;
    if (rd) begin
      case (s_address)
        2'd0:    if (!empty) s_readdata = mem[rd_ptr];
        2'd1:    s_readdata = status;
        2'd2:    s_readdata = {6'b000000, rx_en, irq_en};
        default: s_readdata = 8'h00;
      endcase
    end
  end

endmodule
